imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares one single-port memory interface between the instruction fetch stage (read-only) and the load/store path (read/write).
- Sits between ifetch/exe and the memory/cache port, and keeps at most one transaction outstanding at a time.
- Loads/stores have priority by default. A starvation guard ensures fetch always makes progress.
- A fetch flush (branch taken) discards the response of an in-flight fetch.

Parameters:
- XLEN, 32, address width.
- STARVE_MAX, 4, consecutive lost fetch arbitrations before fetch is forced to win (range 1..15).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request valid
- if_adr_i  in  XLEN  fetch address
- if_flush_i  in  1  flush: drop any outstanding fetch response
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rsp_v_o  out  1  fetch response valid
- if_rdata_o  out  32  fetch instruction
- ls_req_i  in  1  load/store request valid
- ls_we_i  in  1  1=store, 0=load
- ls_be_i  in  4  byte enables
- ls_adr_i  in  XLEN  load/store address
- ls_wdata_i  in  32  store data
- ls_gnt_o  out  1  load/store request accepted this cycle
- ls_rsp_v_o  out  1  load/store response valid (load data or store ack)
- ls_rdata_o  out  32  load data
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_adr_o  out  XLEN  memory address
- mem_wdata_o  out  32  memory write data
- mem_gnt_i  in  1  memory accepts request (handshake completes when mem_req_o & mem_gnt_i)
- mem_rsp_v_i  in  1  memory response valid, 1 per accepted request, at least 1 cycle after grant
- mem_rdata_i  in  32  memory read data

Behaviour:
- FSM states:
  - IDLE: arbitrate and drive the memory request.
  - WAIT_RSP: one request accepted, response pending.
- Reset: state=IDLE, owner=0, drop=0, starve_cnt=0. All outputs 0 while reset_n low; mem_req_o is gated by reset_n.
- IDLE arbitration (combinational):
  - winner = LS if ls_req_i and not (if_req_i and starve_cnt==STARVE_MAX).
  - Otherwise winner = IF if if_req_i.
  - mem_req_o = if_req_i | ls_req_i. mem_* fields are muxed from the winner.
  - A fetch drives we=0 and be=4'hF.
- Grant:
  - if_gnt_o / ls_gnt_o = IDLE & winner matches & mem_gnt_i. Exactly one is high, or neither.
  - On grant: owner <= winner, state <= WAIT_RSP.
- WAIT_RSP:
  - mem_req_o=0, both grants 0.
  - On mem_rsp_v_i: route to owner, same cycle (combinational pass-through of mem_rdata_i), then state <= IDLE.
  - A new request can be issued no earlier than the cycle after the response.
  - Throughput is therefore at most 1 transaction per 2 cycles with 1-cycle memory.
- Response outputs:
  - if_rsp_v_o = WAIT_RSP & mem_rsp_v_i & owner==IF & ~drop & ~if_flush_i.
  - ls_rsp_v_o = WAIT_RSP & mem_rsp_v_i & owner==LS.
  - rdata outputs are always mem_rdata_i; the valids qualify them.
- Flush:
  - if_flush_i in WAIT_RSP with owner==IF sets drop. Drop clears when the response arrives; that response is consumed and suppressed.
  - Flush in the same cycle as the response also suppresses it.
  - Flush in IDLE has no effect on a concurrent fetch request; that request is the new-path fetch and is granted normally.
  - Flush never affects a load/store transaction.
- Starvation counter:
  - In IDLE with if_req_i & ls_req_i & LS granted: starve_cnt++, saturating at STARVE_MAX.
  - On IF grant: starve_cnt <= 0.
  - Otherwise the counter holds.
- Requesters hold their req and payload stable until granted. The arbiter does not latch the payload.
- Reset mid-transaction: return to IDLE immediately. A late mem_rsp_v_i arriving in IDLE is ignored (no rsp valid).

Test Plan:
- Lone fetch: if_req_i=1, if_adr_i=0x100, mem_gnt_i=1, response 1 cycle later with rdata=0x00000013 -> if_gnt_o in cycle 0, mem_adr_o=0x100, mem_be_o=4'hF; if_rsp_v_o=1 and if_rdata_o=0x13 in cycle 1.
- Contention, LS priority: both request, ls_we_i=1, ls_adr_i=0x2000, ls_be_i=4'h3 -> ls_gnt_o first, mem_we_o=1, mem_be_o=4'h3; ls_rsp_v_o at response; fetch granted afterwards only once LS drops its request.
- Starvation: STARVE_MAX=4, both requesting continuously -> LS wins 4 arbitrations, IF wins the 5th, starve_cnt returns to 0, and LS wins the next.
- Flush during fetch: IF granted at 0x104, if_flush_i pulsed 1 cycle before a 3-cycle-late response -> if_rsp_v_o stays 0; the next fetch at 0x400 is granted in the cycle after the response.
- Memory backpressure: mem_gnt_i=0 for 5 cycles with if_req_i=1 -> no grant and mem_req_o=1 held with a stable address; grant occurs on the first cycle mem_gnt_i=1.
- Async reset asserted in WAIT_RSP -> all outputs 0 immediately; after release, a stray mem_rsp_v_i produces no rsp valid and the state is IDLE.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// with one transaction outstanding, LS priority and a fetch starvation guard.
module imem_port_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_adr_i,
    input  logic            if_flush_i,
    output logic            if_gnt_o,
    output logic            if_rsp_v_o,
    output logic [31:0]     if_rdata_o,
    input  logic            ls_req_i,
    input  logic            ls_we_i,
    input  logic [3:0]      ls_be_i,
    input  logic [XLEN-1:0] ls_adr_i,
    input  logic [31:0]     ls_wdata_i,
    output logic            ls_gnt_o,
    output logic            ls_rsp_v_o,
    output logic [31:0]     ls_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic [31:0]     mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rsp_v_i,
    input  logic [31:0]     mem_rdata_i
);
    typedef enum logic { IDLE, WAIT_RSP } state_e;
    typedef enum logic { OWN_IF, OWN_LS } owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    logic       drop_q, drop_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    logic in_idle, in_wait, ls_win, if_win;

    always_comb begin
        in_idle = reset_n && (state_q == IDLE);
        in_wait = reset_n && (state_q == WAIT_RSP);
        ls_win  = ls_req_i && !(if_req_i && (starve_cnt_q == STARVE_LIM));
        if_win  = if_req_i && !ls_win;

        // All outputs are forced low while reset is held, including pass-throughs.
        mem_req_o   = in_idle && (if_req_i || ls_req_i);
        mem_we_o    = reset_n && ls_win && ls_we_i;
        mem_be_o    = !reset_n ? '0 : (ls_win ? ls_be_i : 4'hF);
        mem_adr_o   = !reset_n ? '0 : (ls_win ? ls_adr_i : if_adr_i);
        mem_wdata_o = (reset_n && ls_win) ? ls_wdata_i : '0;

        if_gnt_o    = in_idle && if_win && mem_gnt_i;
        ls_gnt_o    = in_idle && ls_win && mem_gnt_i;

        if_rsp_v_o  = in_wait && mem_rsp_v_i && (owner_q == OWN_IF) && !drop_q && !if_flush_i;
        ls_rsp_v_o  = in_wait && mem_rsp_v_i && (owner_q == OWN_LS);
        if_rdata_o  = reset_n ? mem_rdata_i : '0;
        ls_rdata_o  = reset_n ? mem_rdata_i : '0;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (if_gnt_o || ls_gnt_o) begin
                    state_d = WAIT_RSP;
                    owner_d = ls_gnt_o ? OWN_LS : OWN_IF;
                    drop_d  = 1'b0;
                end
                if (if_gnt_o)
                    starve_cnt_d = '0;
                else if (ls_gnt_o && if_req_i && (starve_cnt_q != STARVE_LIM))
                    starve_cnt_d = starve_cnt_q + 4'd1;
            end
            WAIT_RSP: begin
                // The response retires the transaction and clears any pending drop.
                if (mem_rsp_v_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else if (if_flush_i && (owner_q == OWN_IF)) begin
                    drop_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            drop_q       <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: fetch, LS priority, starvation guard,
// flush handling, memory backpressure and asynchronous reset.
module tb_imem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req_i, if_flush_i, ls_req_i, ls_we_i, mem_gnt_i, mem_rsp_v_i;
    logic [31:0] if_adr_i, ls_adr_i, ls_wdata_i, mem_rdata_i;
    logic [3:0]  ls_be_i;
    logic        if_gnt_o, if_rsp_v_o, ls_gnt_o, ls_rsp_v_o, mem_req_o, mem_we_o;
    logic [31:0] if_rdata_o, ls_rdata_o, mem_adr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    int checks   = 0;
    int failures = 0;

    imem_port_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_flush_i(if_flush_i),
        .if_gnt_o(if_gnt_o), .if_rsp_v_o(if_rsp_v_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_adr_i(ls_adr_i),
        .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rsp_v_o(ls_rsp_v_o),
        .ls_rdata_o(ls_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_adr_o(mem_adr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rsp_v_i(mem_rsp_v_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        if_req_i = 1'b1; if_adr_i = 32'h100; if_flush_i = 1'b0;
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'h3; ls_adr_i = 32'h2000;
        ls_wdata_i = 32'hDEADBEEF;
        mem_gnt_i = 1'b1; mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h13;
        #2;
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_gnts", {30'd0, if_gnt_o, ls_gnt_o}, 32'd0);
        chk("rst_rsps", {30'd0, if_rsp_v_o, ls_rsp_v_o}, 32'd0);
        chk("rst_mem_adr", mem_adr_o, 32'd0);
        chk("rst_if_rdata", if_rdata_o, 32'd0);
        tick(); tick();
        ls_req_i = 1'b0; mem_rsp_v_i = 1'b0; mem_rdata_i = 32'h0;
        reset_n = 1'b1;

        // Lone fetch
        #1;
        chk("fetch_gnt", {31'd0, if_gnt_o}, 32'd1);
        chk("fetch_mem_req", {31'd0, mem_req_o}, 32'd1);
        chk("fetch_adr", mem_adr_o, 32'h100);
        chk("fetch_be", {28'd0, mem_be_o}, 32'hF);
        chk("fetch_we", {31'd0, mem_we_o}, 32'd0);
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h13;
        #1;
        chk("fetch_rsp_v", {31'd0, if_rsp_v_o}, 32'd1);
        chk("fetch_rdata", if_rdata_o, 32'h13);
        chk("fetch_wait_req", {31'd0, mem_req_o}, 32'd0);
        chk("fetch_ls_rsp", {31'd0, ls_rsp_v_o}, 32'd0);
        tick();
        mem_rsp_v_i = 1'b0;

        // Contention: LS wins
        if_req_i = 1'b1; if_adr_i = 32'h200;
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_adr_i = 32'h2000; ls_be_i = 4'h3;
        ls_wdata_i = 32'hDEADBEEF; mem_gnt_i = 1'b1;
        #1;
        chk("cont_gnts", {30'd0, if_gnt_o, ls_gnt_o}, 32'd1);
        chk("cont_we", {31'd0, mem_we_o}, 32'd1);
        chk("cont_be", {28'd0, mem_be_o}, 32'h3);
        chk("cont_adr", mem_adr_o, 32'h2000);
        chk("cont_wdata", mem_wdata_o, 32'hDEADBEEF);
        tick();
        #1;
        chk("cont_wait_gnts", {29'd0, mem_req_o, if_gnt_o, ls_gnt_o}, 32'd0);
        mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h0;
        #1;
        chk("cont_ls_rsp", {30'd0, if_rsp_v_o, ls_rsp_v_o}, 32'd1);
        tick();
        mem_rsp_v_i = 1'b0; ls_req_i = 1'b0;
        #1;
        chk("cont_if_gnt", {30'd0, if_gnt_o, ls_gnt_o}, 32'd2);
        chk("cont_if_adr", mem_adr_o, 32'h200);
        tick();
        if_req_i = 1'b0; mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h55;
        #1;
        chk("cont_if_rsp", {30'd0, if_rsp_v_o, ls_rsp_v_o}, 32'd2);
        tick();
        mem_rsp_v_i = 1'b0;

        // Starvation guard: four LS wins, then IF, then LS again
        if_req_i = 1'b1; if_adr_i = 32'h300; ls_req_i = 1'b1; ls_we_i = 1'b0;
        ls_adr_i = 32'h3000; ls_be_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("starve_gnt%0d", i), {30'd0, if_gnt_o, ls_gnt_o},
                (i == 4) ? 32'd2 : 32'd1);
            chk($sformatf("starve_adr%0d", i), mem_adr_o, (i == 4) ? 32'h300 : 32'h3000);
            tick();
            mem_rsp_v_i = 1'b1; mem_rdata_i = 32'hA0 + i;
            #1;
            chk($sformatf("starve_rsp%0d", i), {30'd0, if_rsp_v_o, ls_rsp_v_o},
                (i == 4) ? 32'd2 : 32'd1);
            tick();
            mem_rsp_v_i = 1'b0;
        end
        if_req_i = 1'b0; ls_req_i = 1'b0;

        // Flush one cycle before a 3-cycle-late response
        if_req_i = 1'b1; if_adr_i = 32'h104;
        #1;
        chk("flush_gnt", {31'd0, if_gnt_o}, 32'd1);
        tick();
        if_adr_i = 32'h400;
        #1;
        chk("flush_wait_gnt", {30'd0, mem_req_o, if_gnt_o}, 32'd0);
        tick();
        if_flush_i = 1'b1;
        #1;
        chk("flush_pulse_rsp", {31'd0, if_rsp_v_o}, 32'd0);
        tick();
        if_flush_i = 1'b0; mem_rsp_v_i = 1'b1; mem_rdata_i = 32'hBAD;
        #1;
        chk("flush_dropped", {31'd0, if_rsp_v_o}, 32'd0);
        chk("flush_rsp_no_gnt", {31'd0, if_gnt_o}, 32'd0);
        tick();
        mem_rsp_v_i = 1'b0;
        #1;
        chk("flush_next_gnt", {31'd0, if_gnt_o}, 32'd1);
        chk("flush_next_adr", mem_adr_o, 32'h400);
        tick();
        if_req_i = 1'b0; mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h1234;
        #1;
        chk("flush_next_rsp", {31'd0, if_rsp_v_o}, 32'd1);
        chk("flush_next_rdata", if_rdata_o, 32'h1234);
        tick();
        mem_rsp_v_i = 1'b0;

        // Flush in IDLE with a new fetch, then flush coincident with the response
        if_req_i = 1'b1; if_adr_i = 32'h500; if_flush_i = 1'b1;
        #1;
        chk("idle_flush_gnt", {31'd0, if_gnt_o}, 32'd1);
        tick();
        if_req_i = 1'b0; mem_rsp_v_i = 1'b1;
        #1;
        chk("same_cyc_flush", {31'd0, if_rsp_v_o}, 32'd0);
        tick();
        if_flush_i = 1'b0; mem_rsp_v_i = 1'b0;

        // Flush never affects load/store
        ls_req_i = 1'b1; ls_we_i = 1'b0;
        #1;
        chk("ls_flush_gnt", {31'd0, ls_gnt_o}, 32'd1);
        tick();
        ls_req_i = 1'b0; if_flush_i = 1'b1;
        tick();
        mem_rsp_v_i = 1'b1; mem_rdata_i = 32'hCAFE;
        #1;
        chk("ls_flush_rsp", {31'd0, ls_rsp_v_o}, 32'd1);
        chk("ls_flush_rdata", ls_rdata_o, 32'hCAFE);
        tick();
        if_flush_i = 1'b0; mem_rsp_v_i = 1'b0;

        // Memory backpressure
        if_req_i = 1'b1; if_adr_i = 32'h600; mem_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_req%0d", i), {30'd0, mem_req_o, if_gnt_o}, 32'd2);
            chk($sformatf("bp_adr%0d", i), mem_adr_o, 32'h600);
            tick();
        end
        mem_gnt_i = 1'b1;
        #1;
        chk("bp_gnt", {31'd0, if_gnt_o}, 32'd1);
        tick();

        // Async reset while waiting for the response
        mem_rsp_v_i = 1'b1; mem_rdata_i = 32'h77;
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_rsp", {30'd0, if_rsp_v_o, ls_rsp_v_o}, 32'd0);
        chk("arst_req", {29'd0, mem_req_o, if_gnt_o, ls_gnt_o}, 32'd0);
        chk("arst_rdata", if_rdata_o, 32'd0);
        tick();
        reset_n = 1'b1; if_req_i = 1'b0; mem_gnt_i = 1'b0;
        #1;
        chk("stray_rsp", {30'd0, if_rsp_v_o, ls_rsp_v_o}, 32'd0);
        mem_rsp_v_i = 1'b0; if_req_i = 1'b1; mem_gnt_i = 1'b1; if_adr_i = 32'h700;
        #1;
        chk("post_rst_idle_gnt", {31'd0, if_gnt_o}, 32'd1);
        tick();
        if_req_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
